// File: rtl/inst_issuer.sv
// Instruction issuer: latches one encoded instruction per accepted request and
// pushes it req_rpt+1 times into the processor control FIFO, honouring backpressure.
module inst_issuer #(
  parameter int INST_WIDTH     = 8,
  parameter int OPCODE_WIDTH   = 2,
  parameter int SRC0_IDX_WIDTH = 2,
  parameter int SRC1_IDX_WIDTH = 2,
  parameter int DST0_IDX_WIDTH = 1,
  parameter int DST1_IDX_WIDTH = 1,
  parameter int RPT_WIDTH      = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [OPCODE_WIDTH-1:0]   req_op,
  input  logic [SRC0_IDX_WIDTH-1:0] req_src0,
  input  logic [SRC1_IDX_WIDTH-1:0] req_src1,
  input  logic [DST0_IDX_WIDTH-1:0] req_dst0,
  input  logic [DST1_IDX_WIDTH-1:0] req_dst1,
  input  logic [RPT_WIDTH-1:0]      req_rpt,
  input  logic                      flush,
  output logic                      ctrl_fifo_enq,
  output logic [INST_WIDTH-1:0]     ctrl_fifo_data_in,
  input  logic                      ctrl_fifo_full,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      issued_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_next;
  logic [INST_WIDTH-1:0] word_q;
  logic [INST_WIDTH-1:0] req_word;
  logic [RPT_WIDTH-1:0]  remaining_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  accept;
  logic                  last_copy;

  assign req_word          = {req_op, req_src0, req_src1, req_dst0, req_dst1};
  assign last_copy         = (remaining_q == '0);
  assign ctrl_fifo_data_in = word_q;
  assign issued_count      = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // A burst ends on its last enqueue unless a new request reloads it in the same cycle.
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (flush) begin
          state_next = IDLE;
        end else if (ctrl_fifo_enq && last_copy) begin
          state_next = accept ? ISSUE : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q == ISSUE);
    ctrl_fifo_enq = (state_q == ISSUE) && !ctrl_fifo_full && !flush;
    req_ready     = !flush && ((state_q == IDLE) || (ctrl_fifo_enq && last_copy));
    accept        = req_valid && req_ready;
  end

  // Word and remaining only move on accept or enqueue, so a full FIFO freezes the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q      <= '0;
      remaining_q <= '0;
      count_q     <= '0;
    end else begin
      if (accept) begin
        word_q      <= req_word;
        remaining_q <= req_rpt;
      end else if (flush && (state_q == ISSUE)) begin
        remaining_q <= '0;
      end else if (ctrl_fifo_enq && !last_copy) begin
        remaining_q <= remaining_q - RPT_WIDTH'(1);
      end
      if (ctrl_fifo_enq && (count_q != '1)) begin
        count_q <= count_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_issuer.sv
// Bench for inst_issuer: a copies-pending model checked every cycle plus
// directed bursts with hand-computed word sequences.
module tb_inst_issuer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [1:0] req_src0;
  logic [1:0] req_src1;
  logic [0:0] req_dst0;
  logic [0:0] req_dst1;
  logic [3:0] req_rpt;
  logic       flush;
  logic       ctrl_fifo_enq;
  logic [7:0] ctrl_fifo_data_in;
  logic       ctrl_fifo_full;
  logic       busy;
  logic [15:0] issued_count;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  int         m_pending = 0;
  logic [7:0] m_word = '0;
  logic [15:0] m_count = '0;

  logic [7:0] obs_q[$];
  int         obs_cyc[$];

  inst_issuer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_op            (req_op),
    .req_src0          (req_src0),
    .req_src1          (req_src1),
    .req_dst0          (req_dst0),
    .req_dst1          (req_dst1),
    .req_rpt           (req_rpt),
    .flush             (flush),
    .ctrl_fifo_enq     (ctrl_fifo_enq),
    .ctrl_fifo_data_in (ctrl_fifo_data_in),
    .ctrl_fifo_full    (ctrl_fifo_full),
    .busy              (busy),
    .issued_count      (issued_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Model: a burst is just a number of copies still owed of one word.
  always @(negedge clk) begin
    logic exp_enq;
    logic exp_ready;
    if (!rst_n) begin
      check_output("rst_enq", 32'(ctrl_fifo_enq), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_count", 32'(issued_count), 32'd0);
      check_output("rst_data", 32'(ctrl_fifo_data_in), 32'd0);
      m_pending = 0;
      m_word    = '0;
      m_count   = '0;
    end else begin
      exp_enq   = (m_pending > 0) && !ctrl_fifo_full && !flush;
      exp_ready = !flush && ((m_pending == 0) || (exp_enq && m_pending == 1));
      check_output("enq", 32'(ctrl_fifo_enq), 32'(exp_enq));
      check_output("ready", 32'(req_ready), 32'(exp_ready));
      check_output("busy", 32'(busy), 32'(m_pending > 0));
      check_output("data", 32'(ctrl_fifo_data_in), 32'(m_word));
      check_output("count", 32'(issued_count), 32'(m_count));
      if (ctrl_fifo_enq) begin
        obs_q.push_back(ctrl_fifo_data_in);
        obs_cyc.push_back(cyc);
      end
      if (flush) begin
        m_pending = 0;
      end else if (exp_enq) begin
        m_pending--;
        if (m_count != 16'hFFFF) m_count++;
      end
      if (req_valid && exp_ready) begin
        m_pending = int'(req_rpt) + 1;
        m_word    = {req_op, req_src0, req_src1, req_dst0, req_dst1};
      end
    end
    cyc++;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    obs_q.delete();
    obs_cyc.delete();
  endtask

  // Holds req_valid until the request is taken; leaves valid low afterwards.
  task automatic apply_stimulus(input logic [1:0] op, input logic [1:0] s0, input logic [1:0] s1,
                                input logic d0, input logic d1, input logic [3:0] rpt);
    bit taken = 0;
    req_op = op; req_src0 = s0; req_src1 = s1;
    req_dst0 = d0; req_dst1 = d1; req_rpt = rpt;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge clk); #1;
      if (req_ready) taken = 1;
    end
    if (!taken) check_output("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk); #1;
      if (!busy) done = 1;
    end
    if (!done) check_output("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_enqs(input int n);
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk); #1;
      if (obs_q.size() >= n) done = 1;
    end
    if (!done) check_output("enq_timeout", 32'(obs_q.size()), 32'(n));
  endtask

  task automatic check_words(input string name, input int n, input logic [7:0] w);
    check_output({name, "_nwords"}, 32'(obs_q.size()), 32'(n));
    foreach (obs_q[i]) check_output({name, "_word"}, 32'(obs_q[i]), 32'(w));
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = '0; req_src0 = '0; req_src1 = '0;
    req_dst0 = '0; req_dst1 = '0; req_rpt = '0;
    flush = 1'b0; ctrl_fifo_full = 1'b0;
    #2;
    check_output("init_enq", 32'(ctrl_fifo_enq), 32'd0);
    check_output("init_busy", 32'(busy), 32'd0);
    check_output("init_data", 32'(ctrl_fifo_data_in), 32'd0);
    check_output("init_count", 32'(issued_count), 32'd0);

    $display("[TB] single word encoding");
    do_reset();
    apply_stimulus(2'd2, 2'd1, 2'd3, 1'b1, 1'b0, 4'd0);
    wait_idle();
    check_words("single", 1, 8'h9E);
    check_output("single_count", 32'(issued_count), 32'd1);
    check_output("single_busy", 32'(busy), 32'd0);

    $display("[TB] burst of four");
    do_reset();
    apply_stimulus(2'd2, 2'd1, 2'd3, 1'b1, 1'b0, 4'd3);
    wait_idle();
    check_words("burst", 4, 8'h9E);
    check_output("burst_count", 32'(issued_count), 32'd4);
    if (obs_cyc.size() == 4)
      check_output("burst_consecutive", 32'(obs_cyc[3] - obs_cyc[0]), 32'd3);

    $display("[TB] backpressure");
    do_reset();
    apply_stimulus(2'd2, 2'd1, 2'd3, 1'b1, 1'b0, 4'd3);
    wait_enqs(2);
    @(posedge clk); #1;
    ctrl_fifo_full = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ctrl_fifo_full = 1'b0;
    wait_idle();
    check_words("bp", 4, 8'h9E);
    check_output("bp_count", 32'(issued_count), 32'd4);
    if (obs_cyc.size() == 4)
      check_output("bp_gap", 32'(obs_cyc[2] - obs_cyc[1]), 32'd3);

    $display("[TB] back-to-back bursts");
    do_reset();
    apply_stimulus(2'd2, 2'd1, 2'd3, 1'b1, 1'b0, 4'd1);
    apply_stimulus(2'd1, 2'd0, 2'd2, 1'b0, 1'b1, 4'd0);
    wait_idle();
    check_output("b2b_nwords", 32'(obs_q.size()), 32'd3);
    if (obs_q.size() == 3) begin
      check_output("b2b_w0", 32'(obs_q[0]), 32'h9E);
      check_output("b2b_w1", 32'(obs_q[1]), 32'h9E);
      check_output("b2b_w2", 32'(obs_q[2]), 32'h49);
      check_output("b2b_span", 32'(obs_cyc[2] - obs_cyc[0]), 32'd2);
    end
    check_output("b2b_count", 32'(issued_count), 32'd3);

    $display("[TB] flush mid-burst");
    do_reset();
    apply_stimulus(2'd2, 2'd1, 2'd3, 1'b1, 1'b0, 4'd7);
    wait_enqs(3);
    @(posedge clk); #1;
    flush = 1'b1;
    #5;
    check_output("flush_enq", 32'(ctrl_fifo_enq), 32'd0);
    check_output("flush_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check_output("flush_busy", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check_words("flush", 3, 8'h9E);
    check_output("flush_count", 32'(issued_count), 32'd3);

    $display("[TB] reset mid-burst");
    do_reset();
    apply_stimulus(2'd2, 2'd1, 2'd3, 1'b1, 1'b0, 4'd7);
    wait_enqs(2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_output("arst_enq", 32'(ctrl_fifo_enq), 32'd0);
    check_output("arst_busy", 32'(busy), 32'd0);
    check_output("arst_count", 32'(issued_count), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_output("arst_ready", 32'(req_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check_output("arst_no_enq", 32'(obs_q.size()), 32'd2);
    check_output("arst_idle", 32'(busy), 32'd0);
    apply_stimulus(2'd1, 2'd0, 2'd2, 1'b0, 1'b1, 4'd1);
    wait_idle();
    check_output("arst_nwords", 32'(obs_q.size()), 32'd4);
    if (obs_q.size() == 4) check_output("arst_new_word", 32'(obs_q[3]), 32'h49);
    check_output("arst_new_count", 32'(issued_count), 32'd2);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
